// File: rtl/bus_addr_dec_tmo_pkg.sv
// Shared bus definitions for the registered slave-select decoder:
// FSM encodings, default geometry and active-low select levels.
package bus_addr_dec_tmo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_ERROR  = 2'b10
    } state_t;

    localparam int DEF_SLAVE_NUM = 8;
    localparam int DEF_ADDR_W    = 30;
    localparam int DEF_IDX_W     = 3;

    localparam logic ASSERT_N   = 1'b0;
    localparam logic DEASSERT_N = 1'b1;

endpackage

// File: rtl/bus_tmo_cnt.sv
// Access timeout counter: cleared while no access is in flight, counts up
// during an access and flags the last permitted cycle.
module bus_tmo_cnt #(
    parameter int TMO_W      = 8,
    parameter int TMO_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    logic [TMO_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + TMO_W'(1);
        end
    end

    // TMO_CYCLES of zero means the access may last forever.
    assign tc = (TMO_CYCLES != 0) && (cnt == TMO_W'(TMO_CYCLES - 1));

endmodule

// File: rtl/bus_addr_dec_tmo.sv
// Registered slave-select decoder with per-slave enable mask, unmapped-slave
// detection and access timeout; errored cycles are terminated locally.
//
// state  | meaning
// IDLE   | waiting for the address strobe, all selects released
// ACCESS | one chip select held low until slave ready or timeout
// ERROR  | one-cycle error response, decoder drives err_rdy_
module bus_addr_dec_tmo
    import bus_addr_dec_tmo_pkg::*;
#(
    parameter int SLAVE_NUM  = DEF_SLAVE_NUM,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int IDX_W      = DEF_IDX_W,
    parameter int TMO_CYCLES = 255,
    parameter int TMO_W      = 8,
    parameter int ECNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_W-1:0]    s_addr,
    input  logic                 s_as_,
    input  logic                 m_rdy_,
    input  logic [SLAVE_NUM-1:0] slave_en,
    input  logic                 err_clr,
    output logic [SLAVE_NUM-1:0] cs_n,
    output logic                 busy,
    output logic                 err,
    output logic                 err_rdy_,
    output logic [ADDR_W-1:0]    err_addr,
    output logic [ECNT_W-1:0]    err_cnt,
    output logic [IDX_W-1:0]     cur_idx
);

    localparam int EN_W = 1 << IDX_W;

    state_t              state;
    state_t              state_nx;
    logic [EN_W-1:0]     en_pad;
    logic [IDX_W-1:0]    dec_idx;
    logic [IDX_W-1:0]    sel_idx;
    logic                dec_ok;
    logic                strobe;
    logic                tmo_tc;
    logic [ADDR_W-1:0]   acc_addr;

    // Indices beyond SLAVE_NUM land on zero-padded enable bits, so one
    // lookup covers both the unmapped and the disabled case.
    assign en_pad  = EN_W'(slave_en);
    assign dec_idx = s_addr[ADDR_W-1 -: IDX_W];
    assign dec_ok  = en_pad[dec_idx];
    assign strobe  = (state == ST_IDLE) && !s_as_;
    assign sel_idx = (state == ST_IDLE) ? dec_idx : cur_idx;

    bus_tmo_cnt #(
        .TMO_W      (TMO_W),
        .TMO_CYCLES (TMO_CYCLES)
    ) u_tmo_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (state != ST_ACCESS),
        .inc   (state == ST_ACCESS),
        .tc    (tmo_tc)
    );

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (!s_as_) begin
                    state_nx = dec_ok ? ST_ACCESS : ST_ERROR;
                end
            end
            ST_ACCESS: begin
                // Ready in the timeout cycle still completes normally.
                if (!m_rdy_) begin
                    state_nx = ST_IDLE;
                end else if (tmo_tc) begin
                    state_nx = ST_ERROR;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs_n     <= '1;
            busy     <= 1'b0;
            err      <= 1'b0;
            err_rdy_ <= DEASSERT_N;
            err_addr <= '0;
            err_cnt  <= '0;
            cur_idx  <= '0;
            acc_addr <= '0;
        end else begin
            cs_n     <= (state_nx == ST_ACCESS) ? ~(SLAVE_NUM'(1) << sel_idx) : '1;
            busy     <= (state_nx == ST_ACCESS);
            err      <= (state_nx == ST_ERROR);
            err_rdy_ <= (state_nx == ST_ERROR) ? ASSERT_N : DEASSERT_N;

            if (strobe) begin
                cur_idx  <= dec_idx;
                acc_addr <= s_addr;
            end

            if (strobe && !dec_ok) begin
                err_addr <= s_addr;
            end else if ((state == ST_ACCESS) && (state_nx == ST_ERROR)) begin
                err_addr <= acc_addr;
            end

            if (err_clr) begin
                err_cnt <= '0;
            end else if ((state_nx == ST_ERROR) && !(&err_cnt)) begin
                err_cnt <= err_cnt + ECNT_W'(1);
            end
        end
    end

endmodule

// File: doc/bus_addr_dec_tmo.md
Name: bus_addr_dec_tmo

Overview:
Parametrised, registered successor of the combinational bus slave-select decoder. Decodes the slave index from the upper bits of the shared word address when a master asserts the address strobe, then holds the selected active-low chip select until the slave answers. Adds three things the combinational decoder lacks: a per-slave enable mask, detection of unmapped or disabled slaves, and an access timeout. On any error the block terminates the bus cycle itself with an error response. It sits between the bus arbiter/master mux and the slave-side ready mux.

Parameters:
SLAVE_NUM, 8, number of slave chip selects (1..2^IDX_W)
ADDR_W, 30, shared word-address width
IDX_W, 3, slave index width, taken from s_addr[ADDR_W-1 -: IDX_W]
TMO_CYCLES, 255, maximum cycles a selected slave may hold the bus; 0 disables the timeout
TMO_W, 8, timeout counter width; must satisfy 2^TMO_W > TMO_CYCLES
ECNT_W, 8, error counter width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
s_addr  in  ADDR_W  shared word address
s_as_  in  1  address strobe, active low
m_rdy_  in  1  muxed slave ready, active low
slave_en  in  SLAVE_NUM  per-slave enable mask, 1 = mapped
err_clr  in  1  synchronous clear of err_cnt
cs_n  out  SLAVE_NUM  registered chip selects, active low, at most one low
busy  out  1  high while in ACCESS
err  out  1  one-cycle error pulse
err_rdy_  out  1  decoder-generated ready, active low, one cycle, terminates an errored access
err_addr  out  ADDR_W  address of the most recent errored access
err_cnt  out  ECNT_W  saturating error count
cur_idx  out  IDX_W  index latched for the current or last access

Behaviour:
- Reset (asynchronous, active-low): state=IDLE, cs_n all 1, busy=0, err=0, err_rdy_=1, err_addr=0, err_cnt=0, cur_idx=0, timeout counter=0. Assertion during ACCESS releases cs_n immediately, without waiting for a clock edge.
- All outputs are registered; no combinational path from inputs to outputs.
- FSM states: IDLE, ACCESS, ERROR.
- IDLE, s_as_ sampled 0: idx = s_addr[ADDR_W-1 -: IDX_W]; latch cur_idx.
  - If idx < SLAVE_NUM and slave_en[idx]=1: go to ACCESS; cs_n[idx]=0 and busy=1 from the next cycle (latency 1); timeout counter cleared to 0.
  - Otherwise: go to ERROR; latch err_addr=s_addr.
- IDLE, s_as_ sampled 1: remain in IDLE, all cs_n high.
- ACCESS, each cycle:
  - m_rdy_=0: go to IDLE; cs_n all 1 next cycle.
  - Else, TMO_CYCLES != 0 and cnt == TMO_CYCLES-1: go to ERROR; err_addr holds the address latched at strobe.
  - Else: cnt+1.
  - The selected cs_n is therefore low for at most TMO_CYCLES cycles.
- ACCESS, boundary cases:
  - m_rdy_=0 in the same cycle the timeout would fire: ready wins, no error.
  - s_as_ activity during ACCESS or ERROR is ignored; a new access starts only from IDLE.
  - slave_en changes during ACCESS do not affect the access in flight.
- ERROR: lasts exactly one cycle with err=1, err_rdy_=0, cs_n all 1, busy=0; then IDLE.
- Back-to-back accesses: a strobe is sampled on the first IDLE cycle after ACCESS or ERROR.
- err_cnt: +1 on each ERROR entry, saturating at all ones.
  - err_clr=1 zeroes it.
  - err_clr coinciding with an error: clear wins, result 0.

Decomposition:
- Shared bus definitions header: FSM state encodings (2-bit), default SLAVE_NUM/ADDR_W/IDX_W, and the existing active-low enable/disable constants. Slave index constants are reused from it.
- One natural sub-module, bus_tmo_cnt: loadable up-counter with terminal-count flag, parametrised by TMO_W and TMO_CYCLES. Everything else stays in one always block for the FSM plus one for outputs.

Test Plan:
Common settings: SLAVE_NUM=6, TMO_CYCLES=4; s_as_ driven low for one cycle at cycle 0 unless stated.
1. s_addr=30'h0800_0000 (idx 1), m_rdy_=0 at cycle 3 -> cs_n=6'b111101 and busy=1 in cycles 1-3; cs_n=6'b111111 at cycle 4; err never 1.
2. s_addr=30'h3000_0000 (idx 6, unmapped) -> cycle 1: err=1, err_rdy_=0, err_addr=30'h3000_0000, cs_n all 1, err_cnt=1; cycle 2: err=0, err_rdy_=1.
3. slave_en=6'b111011, s_addr=30'h1000_0000 (idx 2) -> decode error as in 2; cs_n[2] never low.
4. idx 0, m_rdy_ held 1 -> cs_n[0] low cycles 1-4; cycle 5: err=1, err_rdy_=0, cs_n all 1; then m_rdy_=0 at cycle 4 of a repeat run -> no error, cs_n released at cycle 5.
5. 256 consecutive decode errors with ECNT_W=8 -> err_cnt saturates at 8'hFF; err_clr pulse in the same cycle as an error -> err_cnt=0.
6. reset driven low at cycle 2 of an ACCESS to idx 3 -> cs_n all 1 immediately (asynchronous); after release: IDLE, err_cnt=0; the next strobe is decoded normally.
